audio_mixer_avalon_slave: RTL and testbench

//  Avalon-MM slave driving the R2R speaker DAC from NUM_CH independent square-wave tone channels.

---
 rtl/audio_pkg.sv | 36 +++
 rtl/audio_tone_channel.sv | 86 ++++++++
 rtl/audio_mixer_avalon_slave.sv | 161 ++++++++++++++++
 tb/tb_audio_mixer_avalon_slave.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio mixer Avalon slave.
// Holds the register map (word addresses), CTRL_k / GCTRL bit positions and the
// channel control record unpacked from a CTRL_k write.
package audio_pkg;

   // Word addresses; channel k owns INC at ChanBase+2k and CTRL at ChanBase+2k+1.
   localparam int unsigned AddrGctrl    = 0;
   localparam int unsigned AddrStatus   = 1;
   localparam int unsigned AddrChanBase = 2;

   // GCTRL bits
   localparam int unsigned GctrlMasterEnBit = 0;
   localparam int unsigned GctrlIrqEnBit    = 1;

   // CTRL_k fields
   localparam int unsigned CtrlEnBit  = 0;
   localparam int unsigned CtrlVolLsb = 4;
   localparam int unsigned CtrlDurLsb = 16;
   localparam int unsigned CtrlVolW   = 4;
   localparam int unsigned CtrlDurW   = 16;

   typedef struct packed {
      logic [CtrlDurW-1:0] dur;
      logic [CtrlVolW-1:0] vol;
      logic                en;
   } chan_ctrl_t;

   function automatic chan_ctrl_t decode_ctrl(input logic [31:0] w);
      chan_ctrl_t c;
      c.dur = w[CtrlDurLsb +: CtrlDurW];
      c.vol = w[CtrlVolLsb +: CtrlVolW];
      c.en  = w[CtrlEnBit];
      return c;
   endfunction

endpackage

// File: rtl/audio_tone_channel.sv
// One square-wave tone channel: phase accumulator, ms duration counter,
// expiry pulse and volume-scaled sample.
// Ports:
//  clk_i, rst_i          clock and synchronous active-high reset
//  tick_i                1 ms duration tick
//  inc_we_i / inc_i      phase increment write
//  ctrl_we_i, ctrl_*_i   CTRL write (dur, vol, en)
//  en_o, vol_o, dur_o    live state for readback
//  inc_o                 current phase increment
//  expire_o              one-cycle pulse when a timed note runs out
//  sample_o              vol when enabled and phase msb set, else 0
module audio_tone_channel #(
   parameter int unsigned PHASE_W = 24,
   parameter int unsigned VOL_W   = 4,
   parameter int unsigned DUR_W   = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               tick_i,
   input  logic               inc_we_i,
   input  logic [PHASE_W-1:0] inc_i,
   input  logic               ctrl_we_i,
   input  logic [DUR_W-1:0]   ctrl_dur_i,
   input  logic [VOL_W-1:0]   ctrl_vol_i,
   input  logic               ctrl_en_i,
   output logic               en_o,
   output logic [VOL_W-1:0]   vol_o,
   output logic [DUR_W-1:0]   dur_o,
   output logic [PHASE_W-1:0] inc_o,
   output logic               expire_o,
   output logic [VOL_W-1:0]   sample_o
);

   logic               en_q, en_d;
   logic [VOL_W-1:0]   vol_q, vol_d;
   logic [DUR_W-1:0]   dur_q, dur_d;
   logic [PHASE_W-1:0] inc_q, inc_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic               restart;

   // A CTRL write in the same cycle suppresses expiry.
   assign expire_o = tick_i & en_q & (dur_q == DUR_W'(1)) & ~ctrl_we_i;
   assign restart  = ctrl_we_i & ctrl_en_i & ~en_q;

   always_comb begin
      en_d  = en_q;
      vol_d = vol_q;
      dur_d = dur_q;
      inc_d = inc_we_i ? inc_i : inc_q;
      if (ctrl_we_i) begin
         en_d  = ctrl_en_i;
         vol_d = ctrl_vol_i;
         dur_d = ctrl_dur_i;
      end else if (tick_i && en_q && (dur_q != '0)) begin
         dur_d = dur_q - 1'b1;
         if (dur_q == DUR_W'(1)) begin
            en_d = 1'b0;
         end
      end
      // Stopped channels park at phase 0; a fresh start also begins at 0.
      phase_d = (!en_d || restart) ? '0 : phase_q + inc_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         en_q    <= 1'b0;
         vol_q   <= '0;
         dur_q   <= '0;
         inc_q   <= '0;
         phase_q <= '0;
      end else begin
         en_q    <= en_d;
         vol_q   <= vol_d;
         dur_q   <= dur_d;
         inc_q   <= inc_d;
         phase_q <= phase_d;
      end
   end

   assign en_o     = en_q;
   assign vol_o    = vol_q;
   assign dur_o    = dur_q;
   assign inc_o    = inc_q;
   assign sample_o = (en_q && phase_q[PHASE_W-1]) ? vol_q : '0;

endmodule

// File: rtl/audio_mixer_avalon_slave.sv
// Avalon-MM slave driving the R2R speaker DAC from NUM_CH square-wave tone channels.
// Ports:
//  clock50   50 MHz system clock
//  reset     synchronous active-high reset
//  address   word address; read/write Avalon strobes, zero wait states
//  readdata  registered read data, valid the cycle after read
//  writedata write data
//  irq       irq_en & |done
//  speaker   saturated channel mix, gated by master_en
module audio_mixer_avalon_slave
   import audio_pkg::*;
#(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned OUT_W     = 7,
   parameter int unsigned PHASE_W   = 24,
   parameter int unsigned VOL_W     = 4,
   parameter int unsigned DUR_W     = 16,
   parameter int unsigned TICK_DIV  = 50000,
   parameter int unsigned MIX_SHIFT = 3
) (
   input  logic             clock50,
   input  logic             reset,
   input  logic [3:0]       address,
   input  logic             read,
   output logic [31:0]      readdata,
   input  logic             write,
   input  logic [31:0]      writedata,
   output logic             irq,
   output logic [OUT_W-1:0] speaker
);

   localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned SumW = VOL_W + $clog2(NUM_CH);
   localparam int unsigned MixW = SumW + MIX_SHIFT;

   // Prescaler: free-running 0..TICK_DIV-1, tick on wrap.
   logic [PreW-1:0] pre_q;
   logic            tick;

   assign tick = (pre_q == PreW'(TICK_DIV - 1));

   always_ff @(posedge clock50) begin
      if (reset || tick) pre_q <= '0;
      else               pre_q <= pre_q + 1'b1;
   end

   // Address decode
   logic              gctrl_sel, status_sel;
   logic [NUM_CH-1:0] inc_sel, ctrl_sel;
   chan_ctrl_t        wr_ctrl;

   assign gctrl_sel  = (int'(address) == AddrGctrl);
   assign status_sel = (int'(address) == AddrStatus);
   assign wr_ctrl    = decode_ctrl(writedata);

   // Channels
   logic [NUM_CH-1:0] ch_en, ch_expire;
   logic [VOL_W-1:0]   ch_vol    [NUM_CH];
   logic [VOL_W-1:0]   ch_sample [NUM_CH];
   logic [DUR_W-1:0]   ch_dur    [NUM_CH];
   logic [PHASE_W-1:0] ch_inc    [NUM_CH];

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign inc_sel[k]  = (int'(address) == AddrChanBase + 2 * k);
      assign ctrl_sel[k] = (int'(address) == AddrChanBase + 2 * k + 1);

      audio_tone_channel #(
         .PHASE_W (PHASE_W),
         .VOL_W   (VOL_W),
         .DUR_W   (DUR_W)
      ) u_chan (
         .clk_i      (clock50),
         .rst_i      (reset),
         .tick_i     (tick),
         .inc_we_i   (write & inc_sel[k]),
         .inc_i      (writedata[PHASE_W-1:0]),
         .ctrl_we_i  (write & ctrl_sel[k]),
         .ctrl_dur_i (wr_ctrl.dur[DUR_W-1:0]),
         .ctrl_vol_i (wr_ctrl.vol[VOL_W-1:0]),
         .ctrl_en_i  (wr_ctrl.en),
         .en_o       (ch_en[k]),
         .vol_o      (ch_vol[k]),
         .dur_o      (ch_dur[k]),
         .inc_o      (ch_inc[k]),
         .expire_o   (ch_expire[k]),
         .sample_o   (ch_sample[k])
      );
   end

   // GCTRL / STATUS
   logic              master_en_q, irq_en_q;
   logic [NUM_CH-1:0] done_q, done_d, w1c;

   assign w1c    = (write && status_sel) ? writedata[NUM_CH-1:0] : '0;
   assign done_d = (done_q & ~w1c) | ch_expire;  // set beats clear

   always_ff @(posedge clock50) begin
      if (reset) begin
         master_en_q <= 1'b0;
         irq_en_q    <= 1'b0;
         done_q      <= '0;
      end else begin
         if (write && gctrl_sel) begin
            master_en_q <= writedata[GctrlMasterEnBit];
            irq_en_q    <= writedata[GctrlIrqEnBit];
         end
         done_q <= done_d;
      end
   end

   assign irq = irq_en_q & (|done_q);

   // Readback mux; registered so a same-cycle write returns the old value.
   logic [31:0] rd_val, readdata_q;

   always_comb begin
      rd_val = '0;
      if (gctrl_sel) begin
         rd_val[GctrlMasterEnBit] = master_en_q;
         rd_val[GctrlIrqEnBit]    = irq_en_q;
      end
      if (status_sel) rd_val[NUM_CH-1:0] = done_q;
      for (int k = 0; k < NUM_CH; k++) begin
         if (inc_sel[k]) rd_val[PHASE_W-1:0] = ch_inc[k];
         if (ctrl_sel[k]) begin
            rd_val[CtrlDurLsb +: DUR_W] = ch_dur[k];
            rd_val[CtrlVolLsb +: VOL_W] = ch_vol[k];
            rd_val[CtrlEnBit]           = ch_en[k];
         end
      end
   end

   always_ff @(posedge clock50) begin
      if (reset) readdata_q <= '0;
      else       readdata_q <= read ? rd_val : '0;
   end

   assign readdata = readdata_q;

   // Mixer with saturation
   logic [SumW-1:0]  mix_sum;
   logic [MixW-1:0]  mix_shift;
   logic [OUT_W-1:0] mix_sat, speaker_q;

   always_comb begin
      mix_sum = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         mix_sum = mix_sum + SumW'(ch_sample[k]);
      end
      mix_shift = MixW'(mix_sum) << MIX_SHIFT;
      mix_sat   = (mix_shift > MixW'((2 ** OUT_W) - 1)) ? '1 : mix_shift[OUT_W-1:0];
   end

   always_ff @(posedge clock50) begin
      if (reset) speaker_q <= '0;
      else       speaker_q <= master_en_q ? mix_sat : '0;
   end

   assign speaker = speaker_q;

endmodule

// File: tb/tb_audio_mixer_avalon_slave.sv
// Directed bench for audio_mixer_avalon_slave with TICK_DIV=10. Reads push their
// expected value into a scoreboard queue; a monitor pops and compares when the
// registered readdata is due. Speaker/irq are checked directly against
// hand-derived waveforms.
module tb_audio_mixer_avalon_slave;

   logic        clock50   = 1'b0;
   logic        reset     = 1'b1;
   logic [3:0]  address   = '0;
   logic        read      = 1'b0;
   logic        write     = 1'b0;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic        irq;
   logic [6:0]  speaker;

   localparam logic [3:0] A_GCTRL  = 4'd0;
   localparam logic [3:0] A_STATUS = 4'd1;
   localparam logic [3:0] A_INC0   = 4'd2;
   localparam logic [3:0] A_CTRL0  = 4'd3;
   localparam logic [3:0] A_INC1   = 4'd4;
   localparam logic [3:0] A_CTRL1  = 4'd5;

   always #10 clock50 = ~clock50;

   audio_mixer_avalon_slave #(
      .TICK_DIV (10)
   ) u_dut (
      .clock50   (clock50),
      .reset     (reset),
      .address   (address),
      .read      (read),
      .readdata  (readdata),
      .write     (write),
      .writedata (writedata),
      .irq       (irq),
      .speaker   (speaker)
   );

   typedef struct {
      string       name;
      logic [31:0] exp;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic rd_pend  = 1'b0;
   int   cyc      = 0;   // mirrors the 0..9 prescaler count via cyc % 10

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endfunction

   always @(posedge clock50) begin
      rd_pend <= read;
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   always @(negedge clock50) begin
      if (rd_pend) begin
         exp_t e;
         if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check(e.name, readdata, e.exp);
         end
      end
   end

   task automatic tick1();
      @(posedge clock50);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      address = a; writedata = d; write = 1'b1;
      tick1();
      write = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] e, input string n);
      address = a; read = 1'b1;
      sb_q.push_back('{n, e});
      tick1();
      read = 1'b0;
   endtask

   task automatic rdwr(input logic [3:0] a, input logic [31:0] d, input logic [31:0] e,
                       input string n);
      address = a; writedata = d; read = 1'b1; write = 1'b1;
      sb_q.push_back('{n, e});
      tick1();
      read = 1'b0; write = 1'b0;
   endtask

   task automatic wait_phase(input int ph);
      int k = 0;
      while ((cyc % 10) != ph && k < 20) begin
         tick1();
         k++;
      end
   endtask

   // After the j-th edge following the enabling write, speaker shows the sample of
   // phase (j-1)*inc; the msb pattern is bit 'shift' of (j-1).
   task automatic check_alt(input int first_j, input int n, input logic [6:0] hi,
                            input int shift, input string name);
      for (int j = first_j; j < first_j + n; j++) begin
         tick1();
         check(name, 32'(speaker), (((j - 1) >> shift) & 1) != 0 ? 32'(hi) : 32'd0);
      end
   endtask

   initial begin
      int ticks;
      // 1. reset state
      repeat (3) tick1();
      check("reset_speaker", 32'(speaker), 32'd0);
      check("reset_irq", 32'(irq), 32'd0);
      reset = 1'b0;
      for (int a = 0; a < 16; a++) rd(4'(a), 32'd0, "reset_read");
      wr(4'd12, 32'hFFFF_FFFF);
      rd(4'd12, 32'd0, "unmapped_read");
      check("idle_speaker", 32'(speaker), 32'd0);

      // 2. single tone, vol 15, inc 2^22: 0,0,120,120,...
      wr(A_GCTRL, 32'h1);
      wr(A_INC0, 32'h0040_0000);
      wr(A_CTRL0, 32'h0000_00F1);
      check_alt(1, 12, 7'd120, 1, "tone0_wave");
      rd(A_INC0, 32'h0040_0000, "inc0_readback");
      rd(A_GCTRL, 32'h1, "gctrl_readback");
      rd(A_CTRL0, 32'h0000_00F1, "ctrl0_readback");

      // 3. two in-phase channels saturate; ch1 alone at vol 1 gives 8
      wr(A_CTRL0, 32'h0);
      wr(A_INC0, 32'h0080_0000);
      wr(A_INC1, 32'h0080_0000);
      wr(A_CTRL1, 32'h0000_00F1);
      tick1();
      wr(A_CTRL0, 32'h0000_00F1);
      check_alt(3, 8, 7'd127, 0, "sat_wave");
      wr(A_CTRL0, 32'h0);
      wr(A_CTRL1, 32'h0);
      wr(A_CTRL1, 32'h0000_0011);
      check_alt(1, 6, 7'd8, 0, "vol1_wave");
      wr(A_CTRL1, 32'h0);

      // 4. timed note expires after 3 ticks, irq, W1C
      rdwr(A_GCTRL, 32'h3, 32'h1, "rw_same_addr_old");
      rd(A_GCTRL, 32'h3, "gctrl_irq_en");
      wr(A_CTRL0, 32'h0003_00F1);
      ticks = 0;
      for (int i = 0; i < 40 && ticks < 3; i++) begin
         tick1();
         if ((cyc % 10) == 0) ticks++;
         check("irq_timing", 32'(irq), (ticks >= 3) ? 32'd1 : 32'd0);
      end
      check("irq_reached", 32'(ticks), 32'd3);
      rd(A_CTRL0, 32'h0000_00F0, "ctrl0_expired");
      rd(A_STATUS, 32'h1, "status_done");
      wr(A_STATUS, 32'h1);
      check("irq_cleared", 32'(irq), 32'd0);
      rd(A_STATUS, 32'h0, "status_cleared");

      // 5. CTRL write on the expiry cycle wins
      wait_phase(2);
      wr(A_CTRL0, 32'h0001_00F1);
      wait_phase(9);
      wr(A_CTRL0, 32'h0005_00F1);
      rd(A_CTRL0, 32'h0005_00F1, "reload_wins");
      rd(A_STATUS, 32'h0, "no_done_on_reload");
      check("no_irq_on_reload", 32'(irq), 32'd0);

      // 6. reset mid-note
      wr(A_CTRL0, 32'h0002_00F1);
      repeat (3) tick1();
      reset = 1'b1;
      tick1();
      reset = 1'b0;
      check("midreset_speaker", 32'(speaker), 32'd0);
      check("midreset_irq", 32'(irq), 32'd0);
      rd(A_CTRL0, 32'h0, "midreset_ctrl0");
      rd(A_STATUS, 32'h0, "midreset_status");
      rd(A_GCTRL, 32'h0, "midreset_gctrl");
      repeat (40) tick1();
      rd(A_STATUS, 32'h0, "post_reset_status");

      repeat (2) tick1();
      check("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "timeout");
   end

endmodule
